// File: rtl/fwd_pipe_bank.sv
// fwd_pipe_bank
//   Back-end pipeline register bank (MEM .. WB) holding the register-write
//   record of every in-flight instruction after EXE, with a combinational
//   multi-port forwarding / load-use hazard lookup.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_*               EXE-stage write record entering stage 0
//   stage_en           per-stage advance enable
//   stage_flush        per-stage flush (beats enable)
//   late_valid/data    load data for the pending entry in LATE_STAGE
//   rd_addr            NREAD lookup addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_rf_data         register-file read values, same packing with DATA_W
//   rd_data            forwarded operand per port
//   rd_hit / rd_stall  forwarded from pipeline / youngest producer not ready
//   stall_any          OR of rd_stall
//   stage_valid        per-stage valid
//   wb_wen/addr/data   register-file write port from stage DEPTH-1
module fwd_pipe_bank #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned NREAD      = 2,
  parameter int unsigned LATE_STAGE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_wen,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_ready,
  input  logic [DEPTH-1:0]          stage_en,
  input  logic [DEPTH-1:0]          stage_flush,
  input  logic                      late_valid,
  input  logic [DATA_W-1:0]         late_data,
  input  logic [NREAD*ADDR_W-1:0]   rd_addr,
  input  logic [NREAD*DATA_W-1:0]   rd_rf_data,
  output logic [NREAD*DATA_W-1:0]   rd_data,
  output logic [NREAD-1:0]          rd_hit,
  output logic [NREAD-1:0]          rd_stall,
  output logic                      stall_any,
  output logic [DEPTH-1:0]          stage_valid,
  output logic                      wb_wen,
  output logic [ADDR_W-1:0]         wb_addr,
  output logic [DATA_W-1:0]         wb_data
);

  logic [DEPTH-1:0]  st_valid;
  logic [DEPTH-1:0]  st_wen;
  logic [DEPTH-1:0]  st_ready;
  logic [ADDR_W-1:0] st_addr [DEPTH];
  logic [DATA_W-1:0] st_data [DEPTH];

  // Pending entry in LATE_STAGE receives its load data this cycle.
  logic late_fire;
  assign late_fire = late_valid & st_valid[LATE_STAGE] & ~st_ready[LATE_STAGE];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    localparam bit IS_LATE = (g == LATE_STAGE);

    logic              v;
    logic              w;
    logic              r;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] d;

    if (g == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v  <= '0;
          w  <= '0;
          r  <= '0;
          ad <= '0;
          d  <= '0;
        end else if (stage_flush[g]) begin
          v <= '0;
          w <= '0;
          r <= '0;
        end else if (stage_en[g]) begin
          v  <= in_valid;
          w  <= in_wen;
          r  <= in_ready;
          ad <= in_addr;
          d  <= in_data;
        end else if (IS_LATE && late_fire) begin
          r <= 1'b1;
          d <= late_data;
        end
      end
    end else begin : g_rest
      localparam bit PREV_LATE = ((g - 1) == LATE_STAGE);
      // Load data arriving while the pending entry advances goes straight
      // into this stage instead of being captured upstream.
      logic pass_late;
      assign pass_late = PREV_LATE && late_fire;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v  <= '0;
          w  <= '0;
          r  <= '0;
          ad <= '0;
          d  <= '0;
        end else if (stage_flush[g]) begin
          v <= '0;
          w <= '0;
          r <= '0;
        end else if (stage_en[g]) begin
          if (!stage_en[g-1]) begin
            v <= '0;
            w <= '0;
            r <= '0;
          end else begin
            v  <= st_valid[g-1];
            w  <= st_wen[g-1];
            r  <= st_ready[g-1] | pass_late;
            ad <= st_addr[g-1];
            d  <= pass_late ? late_data : st_data[g-1];
          end
        end else if (IS_LATE && late_fire) begin
          r <= 1'b1;
          d <= late_data;
        end
      end
    end

    assign st_valid[g] = v;
    assign st_wen[g]   = w;
    assign st_ready[g] = r;
    assign st_addr[g]  = ad;
    assign st_data[g]  = d;
  end

  // Lookup: walk candidates oldest to youngest so the last match written
  // is the youngest producer; an older ready match never masks a younger
  // pending one.
  for (genvar p = 0; p < NREAD; p++) begin : g_port
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] rf;
    logic              found;
    logic              fready;
    logic [DATA_W-1:0] fdata;

    assign a  = rd_addr[p*ADDR_W +: ADDR_W];
    assign rf = rd_rf_data[p*DATA_W +: DATA_W];

    always_comb begin
      found  = 1'b0;
      fready = 1'b0;
      fdata  = '0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (st_valid[DEPTH-1-j] && st_wen[DEPTH-1-j] && st_addr[DEPTH-1-j] == a) begin
          found = 1'b1;
          if (st_ready[DEPTH-1-j]) begin
            fready = 1'b1;
            fdata  = st_data[DEPTH-1-j];
          end else if ((DEPTH-1-j) == LATE_STAGE && late_valid) begin
            fready = 1'b1;
            fdata  = late_data;
          end else begin
            fready = 1'b0;
            fdata  = '0;
          end
        end
      end
      // The EXE record is a candidate only out of reset, so every output
      // but rd_data reads zero while rst_n is low.
      if (rst_n && in_valid && in_wen && in_addr == a) begin
        found  = 1'b1;
        fready = in_ready;
        fdata  = in_data;
      end
      if (a == '0) begin
        found = 1'b0;
      end
    end

    assign rd_hit[p]                    = found & fready;
    assign rd_stall[p]                  = found & ~fready;
    assign rd_data[p*DATA_W +: DATA_W]  = (found && fready) ? fdata : rf;
  end

  assign stall_any   = |rd_stall;
  assign stage_valid = st_valid;
  assign wb_wen      = st_valid[DEPTH-1] & st_wen[DEPTH-1] & st_ready[DEPTH-1];
  assign wb_addr     = st_addr[DEPTH-1];
  assign wb_data     = st_data[DEPTH-1];

endmodule

// File: tb/tb_fwd_pipe_bank.sv
`timescale 1ns/100ps
module tb_fwd_pipe_bank;

  localparam logic [31:0] RF0 = 32'hF0F0_0001;
  localparam logic [31:0] RF1 = 32'hF1F1_0002;
  localparam logic [31:0] RF2 = 32'hF2F2_0003;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic        a_in_valid, a_in_wen, a_in_ready, a_late_valid;
  logic [4:0]  a_in_addr;
  logic [31:0] a_in_data, a_late_data;
  logic [1:0]  a_stage_en, a_stage_flush;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_rf_data, a_rd_data;
  logic [1:0]  a_rd_hit, a_rd_stall, a_stage_valid;
  logic        a_stall_any, a_wb_wen;
  logic [4:0]  a_wb_addr;
  logic [31:0] a_wb_data;

  fwd_pipe_bank #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .NREAD(2), .LATE_STAGE(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_wen(a_in_wen), .in_addr(a_in_addr),
    .in_data(a_in_data), .in_ready(a_in_ready),
    .stage_en(a_stage_en), .stage_flush(a_stage_flush),
    .late_valid(a_late_valid), .late_data(a_late_data),
    .rd_addr(a_rd_addr), .rd_rf_data(a_rd_rf_data),
    .rd_data(a_rd_data), .rd_hit(a_rd_hit), .rd_stall(a_rd_stall),
    .stall_any(a_stall_any), .stage_valid(a_stage_valid),
    .wb_wen(a_wb_wen), .wb_addr(a_wb_addr), .wb_data(a_wb_data)
  );

  // DUT B: deeper pipe, three ports, late data in stage 1
  logic        b_in_valid, b_in_wen, b_in_ready, b_late_valid;
  logic [4:0]  b_in_addr;
  logic [31:0] b_in_data, b_late_data;
  logic [2:0]  b_stage_en, b_stage_flush;
  logic [14:0] b_rd_addr;
  logic [95:0] b_rd_rf_data, b_rd_data;
  logic [2:0]  b_rd_hit, b_rd_stall, b_stage_valid;
  logic        b_stall_any, b_wb_wen;
  logic [4:0]  b_wb_addr;
  logic [31:0] b_wb_data;

  fwd_pipe_bank #(.DATA_W(32), .ADDR_W(5), .DEPTH(3), .NREAD(3), .LATE_STAGE(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_wen(b_in_wen), .in_addr(b_in_addr),
    .in_data(b_in_data), .in_ready(b_in_ready),
    .stage_en(b_stage_en), .stage_flush(b_stage_flush),
    .late_valid(b_late_valid), .late_data(b_late_data),
    .rd_addr(b_rd_addr), .rd_rf_data(b_rd_rf_data),
    .rd_data(b_rd_data), .rd_hit(b_rd_hit), .rd_stall(b_rd_stall),
    .stall_any(b_stall_any), .stage_valid(b_stage_valid),
    .wb_wen(b_wb_wen), .wb_addr(b_wb_addr), .wb_data(b_wb_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        iv, iw;
    logic [4:0]  ia;
    logic [31:0] id;
    logic        ir;
    logic [1:0]  en, fl;
    logic        lv;
    logic [31:0] ld;
    logic [4:0]  a0, a1;
    logic [31:0] e0, e1;
    logic [1:0]  ehit, estall, esv;
    logic        ewen;
    logic [4:0]  ewa;
    logic [31:0] ewd;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic b_drive(input logic v, input logic [4:0] ad, input logic [31:0] d, input logic r);
    b_in_valid = v; b_in_wen = v; b_in_addr = ad; b_in_data = d; b_in_ready = r;
  endtask

  initial begin
    //           iv iw ia  id            ir en     fl     lv ld            a0 a1 e0            e1            hit    stall  sv     wen ewa ewd
    vecs[0]  = '{1, 1, 8,  32'h11,       1, 2'b11, 2'b00, 0, 32'h0,        8, 0, 32'h11,       RF1,          2'b01, 2'b00, 2'b00, 0, 0,  32'h0};
    vecs[1]  = '{1, 1, 8,  32'h22,       1, 2'b11, 2'b00, 0, 32'h0,        8, 8, 32'h22,       32'h22,       2'b11, 2'b00, 2'b01, 0, 0,  32'h0};
    vecs[2]  = '{0, 0, 0,  32'h0,        0, 2'b11, 2'b00, 0, 32'h0,        8, 5, 32'h22,       RF1,          2'b01, 2'b00, 2'b11, 1, 8,  32'h11};
    vecs[3]  = '{1, 1, 9,  32'h0BAD,     0, 2'b11, 2'b00, 0, 32'h0,        9, 8, RF0,          32'h22,       2'b10, 2'b01, 2'b10, 1, 8,  32'h22};
    vecs[4]  = '{0, 0, 0,  32'h0,        0, 2'b11, 2'b00, 1, 32'hCAFE,     9, 9, 32'hCAFE,     32'hCAFE,     2'b11, 2'b00, 2'b01, 0, 0,  32'h0};
    vecs[5]  = '{0, 0, 0,  32'h0,        0, 2'b11, 2'b00, 0, 32'h0,        9, 0, 32'hCAFE,     RF1,          2'b01, 2'b00, 2'b10, 1, 9,  32'hCAFE};
    vecs[6]  = '{1, 1, 10, 32'h0BAD,     0, 2'b11, 2'b00, 0, 32'h0,       10, 0, RF0,          RF1,          2'b00, 2'b01, 2'b00, 0, 0,  32'h0};
    vecs[7]  = '{0, 0, 0,  32'h0,        0, 2'b00, 2'b00, 1, 32'hBEEF,    10,10, 32'hBEEF,     32'hBEEF,     2'b11, 2'b00, 2'b01, 0, 0,  32'h0};
    vecs[8]  = '{0, 0, 0,  32'h0,        0, 2'b11, 2'b00, 0, 32'h1234,    10, 0, 32'hBEEF,     RF1,          2'b01, 2'b00, 2'b01, 0, 0,  32'h0};
    vecs[9]  = '{1, 1, 0,  32'h5,        1, 2'b11, 2'b00, 0, 32'h0,        0,10, RF0,          32'hBEEF,     2'b10, 2'b00, 2'b10, 1, 10, 32'hBEEF};
    vecs[10] = '{1, 1, 12, 32'h33,       1, 2'b11, 2'b00, 0, 32'h0,        0,12, RF0,          32'h33,       2'b10, 2'b00, 2'b01, 0, 0,  32'h0};
    vecs[11] = '{1, 1, 13, 32'h44,       1, 2'b10, 2'b00, 0, 32'h0,       12,13, 32'h33,       32'h44,       2'b11, 2'b00, 2'b11, 1, 0,  32'h5};
    vecs[12] = '{0, 0, 0,  32'h0,        0, 2'b00, 2'b01, 0, 32'h0,       12,13, 32'h33,       RF1,          2'b01, 2'b00, 2'b01, 0, 0,  32'h0};
    vecs[13] = '{0, 0, 0,  32'h0,        0, 2'b11, 2'b00, 0, 32'h0,       12, 0, RF0,          RF1,          2'b00, 2'b00, 2'b00, 0, 0,  32'h0};
    vecs[14] = '{0, 0, 0,  32'h0,        0, 2'b11, 2'b00, 0, 32'h0,        0, 0, RF0,          RF1,          2'b00, 2'b00, 2'b00, 0, 0,  32'h0};
    vecs[15] = '{1, 1, 14, 32'h55,       1, 2'b11, 2'b00, 0, 32'h0,       14, 0, 32'h55,       RF1,          2'b01, 2'b00, 2'b00, 0, 0,  32'h0};
    vecs[16] = '{1, 1, 14, 32'h66,       0, 2'b11, 2'b00, 0, 32'h0,       14,14, RF0,          RF1,          2'b00, 2'b11, 2'b01, 0, 0,  32'h0};
    vecs[17] = '{0, 0, 0,  32'h0,        0, 2'b00, 2'b00, 0, 32'h0,       14, 3, RF0,          RF1,          2'b00, 2'b01, 2'b11, 1, 14, 32'h55};
    vecs[18] = '{0, 0, 0,  32'h0,        0, 2'b11, 2'b00, 0, 32'h0,       14, 0, RF0,          RF1,          2'b00, 2'b01, 2'b11, 1, 14, 32'h55};
    vecs[19] = '{0, 0, 0,  32'h0,        0, 2'b00, 2'b00, 1, 32'h77,      14, 0, RF0,          RF1,          2'b00, 2'b01, 2'b10, 0, 0,  32'h0};
    vecs[20] = '{1, 1, 15, 32'h88,       1, 2'b11, 2'b00, 0, 32'h0,        0, 0, RF0,          RF1,          2'b00, 2'b00, 2'b10, 0, 0,  32'h0};
    vecs[21] = '{1, 1, 16, 32'h99,       1, 2'b11, 2'b00, 0, 32'h0,       15,16, 32'h88,       32'h99,       2'b11, 2'b00, 2'b01, 0, 0,  32'h0};

    rst_n = 1'b0;
    a_in_valid = 0; a_in_wen = 0; a_in_addr = '0; a_in_data = '0; a_in_ready = 0;
    a_stage_en = '0; a_stage_flush = '0; a_late_valid = 0; a_late_data = '0;
    a_rd_addr = '0; a_rd_rf_data = {RF1, RF0};
    b_drive(0, 0, 0, 0);
    b_stage_en = '0; b_stage_flush = '0; b_late_valid = 0; b_late_data = '0;
    b_rd_addr = '0; b_rd_rf_data = {RF2, RF1, RF0};

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_sv", 0, 32'(a_stage_valid), 32'h0);
    chk("rst_wen", 0, 32'(a_wb_wen), 32'h0);
    chk("rst_waddr", 0, 32'(a_wb_addr), 32'h0);
    chk("rst_wdata", 0, a_wb_data, 32'h0);
    chk("rst_rd0", 0, a_rd_data[31:0], RF0);
    chk("rst_hit", 0, 32'(a_rd_hit), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_in_valid = vecs[i].iv; a_in_wen = vecs[i].iw; a_in_addr = vecs[i].ia;
      a_in_data = vecs[i].id; a_in_ready = vecs[i].ir;
      a_stage_en = vecs[i].en; a_stage_flush = vecs[i].fl;
      a_late_valid = vecs[i].lv; a_late_data = vecs[i].ld;
      a_rd_addr = {vecs[i].a1, vecs[i].a0};
      #2;
      chk("rd_data0", i, a_rd_data[31:0], vecs[i].e0);
      chk("rd_data1", i, a_rd_data[63:32], vecs[i].e1);
      chk("rd_hit", i, 32'(a_rd_hit), 32'(vecs[i].ehit));
      chk("rd_stall", i, 32'(a_rd_stall), 32'(vecs[i].estall));
      chk("stall_any", i, 32'(a_stall_any), 32'(|vecs[i].estall));
      chk("stage_valid", i, 32'(a_stage_valid), 32'(vecs[i].esv));
      chk("wb_wen", i, 32'(a_wb_wen), 32'(vecs[i].ewen));
      if (vecs[i].ewen) begin
        chk("wb_addr", i, 32'(a_wb_addr), 32'(vecs[i].ewa));
        chk("wb_data", i, a_wb_data, vecs[i].ewd);
      end
    end

    // Reset mid-stream: both stages full (r16 in MEM, r15 in WB)
    @(negedge clk);
    a_in_valid = 0; a_in_wen = 0; a_stage_en = 2'b00; a_late_valid = 0;
    a_rd_addr = {5'd16, 5'd15};
    #1;
    chk("mid_sv_pre", 0, 32'(a_stage_valid), 32'h3);
    chk("mid_wb_pre", 0, a_wb_data, 32'h88);
    rst_n = 1'b0;
    #1;
    chk("mid_sv", 0, 32'(a_stage_valid), 32'h0);
    chk("mid_wen", 0, 32'(a_wb_wen), 32'h0);
    chk("mid_hit", 0, 32'(a_rd_hit), 32'h0);
    chk("mid_rd0", 0, a_rd_data[31:0], RF0);
    chk("mid_rd1", 0, a_rd_data[63:32], RF1);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_sv_post", 0, 32'(a_stage_valid), 32'h0);

    // DUT B: fill r4 (ready), r5 (pending load), r6 (ready)
    b_stage_en = 3'b111;
    b_drive(1, 5'd4, 32'hA1, 1);
    @(negedge clk);
    b_drive(1, 5'd5, 32'hB2, 0);
    @(negedge clk);
    b_drive(1, 5'd6, 32'hC3, 1);
    @(negedge clk);
    // stages now: S0=r6, S1=r5 pending, S2=r4; EXE has a younger r4
    b_stage_en = 3'b000;
    b_drive(1, 5'd4, 32'hD4, 1);
    b_late_valid = 0;
    b_rd_addr = {5'd4, 5'd5, 5'd6};
    #2;
    chk("b_rd0", 0, b_rd_data[31:0], 32'hC3);
    chk("b_rd1", 0, b_rd_data[63:32], RF1);
    chk("b_rd2", 0, b_rd_data[95:64], 32'hD4);
    chk("b_hit", 0, 32'(b_rd_hit), 32'h5);
    chk("b_stall", 0, 32'(b_rd_stall), 32'h2);
    chk("b_stall_any", 0, 32'(b_stall_any), 32'h1);
    chk("b_sv", 0, 32'(b_stage_valid), 32'h7);
    chk("b_wb", 0, b_wb_data, 32'hA1);
    b_late_valid = 1; b_late_data = 32'hE5;
    #1;
    chk("b_rd1_late", 1, b_rd_data[63:32], 32'hE5);
    chk("b_hit_late", 1, 32'(b_rd_hit), 32'h7);
    chk("b_stall_any_late", 1, 32'(b_stall_any), 32'h0);
    b_drive(0, 0, 0, 0);
    #1;
    chk("b_rd2_old", 2, b_rd_data[95:64], 32'hA1);
    b_stage_en = 3'b111;
    @(negedge clk);
    // pending r5 advanced with late data into WB
    b_late_valid = 0;
    b_rd_addr = {5'd7, 5'd6, 5'd5};
    #2;
    chk("b_rd0_wb", 3, b_rd_data[31:0], 32'hE5);
    chk("b_rd1_s1", 3, b_rd_data[63:32], 32'hC3);
    chk("b_rd2_rf", 3, b_rd_data[95:64], RF2);
    chk("b_sv2", 3, 32'(b_stage_valid), 32'h6);
    chk("b_wen2", 3, 32'(b_wb_wen), 32'h1);
    chk("b_waddr2", 3, 32'(b_wb_addr), 32'h5);
    chk("b_wdata2", 3, b_wb_data, 32'hE5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_pipe_bank.md
Name: fwd_pipe_bank

Overview:
- Parametrised back-end pipeline register bank with a built-in N-port forwarding/hazard lookup, for the MIPS 5-stage CPU and its deeper successors.
- Holds the register-write record (valid, wen, dest addr, data, ready) of every in-flight instruction after EXE, DEPTH stages deep, with per-stage enable/flush.
- Answers NREAD operand lookups per cycle: youngest matching producer data, or a stall request when that data is not yet produced (load-use).
- The last stage drives the register-file write port.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 5, register address width.
- DEPTH, 2, number of stages held (stage 0 = MEM, stage DEPTH-1 = WB); legal range 1..8.
- NREAD, 2, number of lookup ports (rs, rt).
- LATE_STAGE, 0, stage where pending (load) entries receive late_data; must be < DEPTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  EXE-stage instruction valid.
- in_wen  in  1  EXE-stage instruction writes a register.
- in_addr  in  ADDR_W  destination register.
- in_data  in  DATA_W  EXE result (ALU out).
- in_ready  in  1  in_data is final (0 for loads).
- stage_en  in  DEPTH  per-stage advance enable.
- stage_flush  in  DEPTH  per-stage flush.
- late_valid  in  1  late_data valid this cycle.
- late_data  in  DATA_W  memory read data for the entry in LATE_STAGE.
- rd_addr  in  NREAD*ADDR_W  lookup addresses, port i at [i*ADDR_W +: ADDR_W].
- rd_rf_data  in  NREAD*DATA_W  register-file read values.
- rd_data  out  NREAD*DATA_W  forwarded operand.
- rd_hit  out  NREAD  forwarded from pipeline.
- rd_stall  out  NREAD  youngest producer not ready.
- stall_any  out  1  OR of rd_stall.
- stage_valid  out  DEPTH  per-stage valid.
- wb_wen  out  1  valid & wen & ready of stage DEPTH-1.
- wb_addr  out  ADDR_W  stage DEPTH-1 addr.
- wb_data  out  DATA_W  stage DEPTH-1 data.

Behaviour:
- Reset: rst_n=0 asynchronously clears valid, wen, ready, addr and data of all stages to 0. All outputs are then 0, except rd_data, which equals rd_rf_data.
- Stage k updates only at posedge with stage_en[k]=1. Priority per stage: flush > enable > hold.
  - Flush: clears valid and wen; data don't-care.
  - Stage 0 source: in_* inputs.
  - Stage k>0 source: stage k-1.
  - If stage_en[k]=1 and stage_en[k-1]=0, stage k loads a bubble (valid=0). Stage 0 never bubbles from inputs; an EXE bubble arrives as in_valid=0.
- Late capture: an entry in LATE_STAGE with valid & !ready, late_valid=1 and the stage not advancing captures late_data and sets ready.
  - If it advances in the same cycle, the next stage receives late_data with ready=1.
  - If late_valid=0 on advance, ready stays 0 (implementation error; the bench flags wb_wen suppressed).
- Lookup (combinational, zero latency, per port independently):
  - Candidates in age order youngest first: inputs (in_valid & in_wen), then stages 0..DEPTH-1 (valid & wen).
  - A candidate matches if addr == rd_addr and rd_addr != 0.
  - The first match wins:
    - winner ready: rd_data = its data, rd_hit=1.
    - winner pending in LATE_STAGE with late_valid: rd_data = late_data, rd_hit=1.
    - otherwise: rd_stall=1, rd_hit=0, rd_data = rd_rf_data.
  - No match: rd_data = rd_rf_data, hit=stall=0.
  - Older matches never override the youngest, even if the youngest is pending.
- wb_* reflect stage DEPTH-1 registers directly; wb_wen requires ready.
- No internal stall generation: the pipeline controller uses stall_any to drop stage_en/flush upstream. Simultaneous flush of stage 0 with stall_any is legal.

Test Plan:
- Reset mid-stream: stages full, rst_n low for 3 ns between edges -> stage_valid=0, wb_wen=0 immediately; rd_hit=0, rd_data=rd_rf_data.
- Back-to-back forward: in addr=8, data=0x11, ready=1, then addr=8, data=0x22 one cycle later; lookup r8 each cycle -> 0x11 from inputs, then 0x22 (youngest), hit=1; stage 1 later writes 0x11 with wb_wen=1.
- Load-use: in addr=9, ready=0; lookup r9 same cycle -> rd_stall=1, stall_any=1. Next cycle in stage 0 with late_valid=1, late_data=0xCAFE -> rd_data=0xCAFE, hit=1, stall=0. wb_data=0xCAFE one cycle later.
- Zero register: write to r0 with data 0x5 and lookup r0 -> hit=0, rd_data=rd_rf_data.
- Stall bubble and flush: stage_en=2'b10 for one cycle -> stage 1 becomes a bubble (wb_wen=0), stage 0 holds. stage_flush[0]=1 -> stage_valid[0]=0 and no subsequent writeback.
- Parameter sweep: DEPTH=3, NREAD=3, LATE_STAGE=1 -> three independent ports resolve to different stages simultaneously with correct youngest-first priority.
